// File: rtl/rca_seq_ctrl_if.sv
// Request/result bundle between a requester and the chunked adder sequencer.
// Signals:
//   start  request, sampled only while the sequencer is idle
//   a, b   WIDTH-bit operands, captured on an accepted start
//   c_in   carry-in, captured on an accepted start
//   busy   high while an operation is in progress
//   done   one-cycle pulse when sum/c_out/ovf have been updated
//   sum    a + b + c_in modulo 2^WIDTH
//   c_out  unsigned carry out of the top bit
//   ovf    signed overflow of the addition
// Modports: master = requester, slave = sequencer.
interface rca_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle adder: one shared 4-bit ripple-carry adder processes the
// operands one nibble per cycle, LSB nibble first, with the carry between
// nibbles held in a register. Results are published all at once on done.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active high; aborts any operation in flight
//   bus  rca_seq_ctrl_if.slave (start/a/b/c_in in, busy/done/sum/c_out/ovf out)
// Parameters:
//   WIDTH  operand/sum width, multiple of 4 and at least 4

module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = c[4];
endmodule

// state | meaning
// IDLE  | waiting for start; results hold their last values
// RUN   | adding one nibble per cycle, idx selects the nibble
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    rca_seq_ctrl_if.slave bus
);
    localparam int NCHUNK = WIDTH / 4;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] work_next;
    logic             carry_r;
    logic [IDX_W-1:0] idx;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;

    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic [3:0]       add_s;
    logic             add_c;
    logic             ovf_next;

    always_comb begin
        add_a = a_r[4*idx +: 4];
        add_b = b_r[4*idx +: 4];
    end

    rca_4bit u_rca (
        .a     (add_a),
        .b     (add_b),
        .c_in  (carry_r),
        .s     (add_s),
        .c_out (add_c)
    );

    // Work value including the nibble being produced this cycle, so the final
    // edge can publish the complete sum without an extra cycle.
    always_comb begin
        work_next              = work_r;
        work_next[4*idx +: 4]  = add_s;
        ovf_next = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                   (work_next[WIDTH-1] != a_r[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            work_r  <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        carry_r <= bus.c_in;
                        work_r  <= '0;
                        idx     <= '0;
                        busy_r  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    work_r  <= work_next;
                    carry_r <= add_c;
                    if (idx == LAST_IDX) begin
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        sum_r   <= work_next;
                        c_out_r <= add_c;
                        ovf_r   <= ovf_next;
                        idx     <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.sum   = sum_r;
    assign bus.c_out = c_out_r;
    assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: a 16-bit instance checked every cycle against a
// transaction-level model (accept -> fixed latency -> result), plus a 4-bit
// instance exercised directly.
module tb_rca_seq_ctrl;
    localparam int NCHUNK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rca_seq_ctrl_if #(.WIDTH(16)) bus ();
    rca_seq_ctrl_if #(.WIDTH(4))  bus4 ();

    rca_seq_ctrl #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rca_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (16-bit) ----------------
    int          cyc = 0;
    int          m_rem = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_sum = '0;
    logic        m_cout = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] p_sum = '0;
    logic        p_cout = 1'b0;
    logic        p_ovf = 1'b0;
    bit          mon_en = 1'b0;
    int          dut_done_cnt = 0;
    int          done_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            cyc++;
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (bus.start) begin
                    {p_cout, p_sum} = 17'(bus.a) + 17'(bus.b) + 17'(bus.c_in);
                    p_ovf = (bus.a[15] == bus.b[15]) && (p_sum[15] != bus.a[15]);
                    m_rem = NCHUNK;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_sum  = p_sum;
                    m_cout = p_cout;
                    m_ovf  = p_ovf;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy",  bus.busy,  32'(m_rem != 0));
            check("done",  bus.done,  32'(m_done));
            check("sum",   bus.sum,   32'(m_sum));
            check("c_out", bus.c_out, 32'(m_cout));
            check("ovf",   bus.ovf,   32'(m_ovf));
        end
        if (bus.done) begin
            dut_done_cnt++;
            done_q.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cyc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge clk);
            if (bus.done) found = 1'b1;
        end
        check("done_timeout", 32'(found), 32'd1);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
        int t0;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.c_in  = tc;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        t0 = cyc;
        wait_done(20);
        check("latency", 32'(cyc - t0), 32'(NCHUNK));
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        logic [3:0]  a4, b4;
        logic        c4;
        logic [4:0]  r4;
        int          d0;

        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.c_in   = 1'b0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus4.c_in  = 1'b0;

        repeat (3) step();
        check("rst_busy",  bus.busy,  0);
        check("rst_done",  bus.done,  0);
        check("rst_sum",   bus.sum,   0);
        check("rst_c_out", bus.c_out, 0);
        check("rst_ovf",   bus.ovf,   0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step();

        // 1: carry ripples through all nibbles
        run_op(16'hFFFF, 16'h0001, 1'b0);
        check("t1_sum",   bus.sum,   32'h0000);
        check("t1_c_out", bus.c_out, 1);
        check("t1_ovf",   bus.ovf,   0);
        step();

        // 2: signed overflow, then carry-in only
        run_op(16'h7FFF, 16'h0001, 1'b0);
        check("t2_sum",   bus.sum,   32'h8000);
        check("t2_c_out", bus.c_out, 0);
        check("t2_ovf",   bus.ovf,   1);
        step();
        run_op(16'h0000, 16'h0000, 1'b1);
        check("t2_cin_sum", bus.sum, 32'h0001);
        step();

        // 3: start during busy is ignored
        d0 = dut_done_cnt;
        bus.a = 16'h1234; bus.b = 16'h1111; bus.c_in = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.a = 16'hFFFF; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(20);
        check("t3_sum", bus.sum, 32'h2345);
        repeat (8) step();
        check("t3_one_done", 32'(dut_done_cnt - d0), 1);

        // 4: reset mid-operation
        bus.a = 16'hABCD; bus.b = 16'h1357; bus.c_in = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        #1 rst = 1'b1;
        #1;
        check("t4_busy",  bus.busy,  0);
        check("t4_done",  bus.done,  0);
        check("t4_sum",   bus.sum,   0);
        check("t4_c_out", bus.c_out, 0);
        step();
        rst = 1'b0;
        d0 = dut_done_cnt;
        repeat (8) step();
        check("t4_no_done", 32'(dut_done_cnt - d0), 0);
        run_op(16'h4000, 16'h4000, 1'b1);
        check("t4_new_sum", bus.sum, 32'h8001);
        check("t4_new_ovf", bus.ovf, 1);
        step();

        // 5: start held high, operands change every cycle
        done_q.delete();
        bus.start = 1'b1;
        for (int i = 0; i < 27; i++) begin
            bus.a    = pick16();
            bus.b    = pick16();
            bus.c_in = 1'($urandom);
            step();
        end
        bus.start = 1'b0;
        repeat (8) step();
        check("t5_ops", 32'(done_q.size() >= 5), 1);
        for (int i = 1; i < done_q.size(); i++)
            check("t5_period", 32'(done_q[i] - done_q[i-1]), 32'(NCHUNK + 1));

        // random traffic, checked cycle by cycle by the model
        for (int i = 0; i < 400; i++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = pick16();
            bus.b     = pick16();
            bus.c_in  = 1'($urandom);
            step();
        end
        bus.start = 1'b0;
        repeat (8) step();

        // 6: WIDTH=4 instance
        bus4.a = 4'h9; bus4.b = 4'h8; bus4.c_in = 1'b1; bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        check("t6_busy", bus4.busy, 1);
        check("t6_done_early", bus4.done, 0);
        step();
        check("t6_done",  bus4.done,  1);
        check("t6_sum",   bus4.sum,   32'h2);
        check("t6_c_out", bus4.c_out, 1);
        check("t6_ovf",   bus4.ovf,   1);
        check("t6_idle",  bus4.busy,  0);
        for (int i = 0; i < 20; i++) begin
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            c4 = 1'($urandom);
            r4 = 5'(a4) + 5'(b4) + 5'(c4);
            bus4.a = a4; bus4.b = b4; bus4.c_in = c4; bus4.start = 1'b1;
            step();
            bus4.start = 1'b0;
            step();
            check("w4_done",  bus4.done,  1);
            check("w4_sum",   bus4.sum,   32'(r4[3:0]));
            check("w4_c_out", bus4.c_out, 32'(r4[4]));
            check("w4_ovf",   bus4.ovf,   32'((a4[3] == b4[3]) && (r4[3] != a4[3])));
        end

        // random 16-bit ops through the full handshake
        for (int i = 0; i < 10; i++) begin
            ra = pick16();
            rb = pick16();
            rc = 1'($urandom);
            run_op(ra, rb, rc);
            check("rand_sum", bus.sum, 32'(16'(ra + rb + 16'(rc))));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
